alu_issue_arbiter: RTL

ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

---
 rtl/alu_issue_arbiter_pkg.sv | 25 ++
 rtl/alu_issue_arbiter_rr_picker.sv | 29 ++
 rtl/alu_issue_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/alu_issue_arbiter_pkg.sv
// Shared constants for the ALU issue path: datapath width, opcode width and ALU opcode encodings.
package alu_issue_arbiter_pkg;

  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 4;

  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_ADD    = 4'd0;
  localparam alu_op_t ALU_SUB    = 4'd1;
  localparam alu_op_t ALU_AND    = 4'd2;
  localparam alu_op_t ALU_OR     = 4'd3;
  localparam alu_op_t ALU_XOR    = 4'd4;
  localparam alu_op_t ALU_SLL    = 4'd5;
  localparam alu_op_t ALU_SRL    = 4'd6;
  localparam alu_op_t ALU_SRA    = 4'd7;
  localparam alu_op_t ALU_SLT    = 4'd8;
  localparam alu_op_t ALU_SLTU   = 4'd9;
  localparam alu_op_t ALU_BEQ    = 4'd10;
  localparam alu_op_t ALU_BGE    = 4'd11;
  localparam alu_op_t ALU_BGEU   = 4'd12;
  localparam alu_op_t ALU_BNE    = 4'd13;
  localparam alu_op_t ALU_ADD_PC = 4'd14;

endpackage

// File: rtl/alu_issue_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set request at or after ptr_i, wrapping.
module alu_issue_arbiter_rr_picker #(
  parameter int IDX_W = 2
) (
  input  logic [(1<<IDX_W)-1:0] req_i,
  input  logic [IDX_W-1:0]      ptr_i,
  output logic                  gnt_valid_o,
  output logic [IDX_W-1:0]      gnt_idx_o
);

  localparam int N = 1 << IDX_W;

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset back to ptr_i so the nearest hit is written last.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    idx         = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr_i + IDX_W'(k);
      if (req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = idx;
      end
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Picks ready RS entries round-robin, issues one per cycle to a single-cycle ALU, and buffers
// results in a 2-deep writeback FIFO; a 2-credit counter keeps the FIFO from overflowing.
module alu_issue_arbiter
  import alu_issue_arbiter_pkg::*;
#(
  parameter int RS_WIDTH = 2
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rdy_in,
  input  logic                           clear,
  input  logic [(1<<RS_WIDTH)-1:0]       rs_ready,
  input  logic [(1<<RS_WIDTH)*XLEN-1:0]  rs_a,
  input  logic [(1<<RS_WIDTH)*XLEN-1:0]  rs_b,
  input  logic [(1<<RS_WIDTH)*ALU_OP_W-1:0] rs_op,
  output logic                           issue_valid,
  output logic [RS_WIDTH-1:0]            issue_index,
  output logic                           cal,
  output logic [XLEN-1:0]                alu_a,
  output logic [XLEN-1:0]                alu_b,
  output logic [ALU_OP_W-1:0]            alu_op,
  output logic [RS_WIDTH-1:0]            alu_index,
  input  logic                           alu_done,
  input  logic [RS_WIDTH-1:0]            alu_done_index,
  input  logic [XLEN-1:0]                alu_result,
  output logic                           wb_valid,
  output logic [RS_WIDTH-1:0]            wb_index,
  output logic [XLEN-1:0]                wb_result,
  input  logic                           wb_ack
);

  localparam int RS_SIZE = 1 << RS_WIDTH;

  logic [RS_SIZE-1:0]  pending_q, pending_d;
  logic [RS_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0]          cnt_q, cnt_d;

  logic [RS_WIDTH-1:0] fifo_idx_q [2];
  logic [XLEN-1:0]     fifo_res_q [2];
  logic                fifo_rd_q, fifo_wr_q;
  logic [1:0]          fifo_cnt_q;

  logic                cal_q, issue_valid_q;
  logic [RS_WIDTH-1:0] issue_index_q, alu_index_q;
  logic [XLEN-1:0]     alu_a_q, alu_b_q;
  logic [ALU_OP_W-1:0] alu_op_q;

  logic                gnt_valid;
  logic [RS_WIDTH-1:0] gnt_idx;
  logic                flush, push, pop, issue;

  alu_issue_arbiter_rr_picker #(.IDX_W(RS_WIDTH)) u_rr_picker (
    .req_i      (rs_ready & ~pending_q),
    .ptr_i      (rr_ptr_q),
    .gnt_valid_o(gnt_valid),
    .gnt_idx_o  (gnt_idx)
  );

  // Writeback handshake: the head transfers on a cycle with wb_valid=1, wb_ack=1 and rdy_in=1;
  // wb_ack while wb_valid=0 has no effect, and the head stays stable until taken.
  assign flush = rdy_in & clear;
  assign pop   = rdy_in & ~clear & wb_valid & wb_ack;
  assign push  = alu_done & ~flush;
  // A pop in the same cycle frees the credit the new issue needs.
  assign issue = rdy_in & ~clear & gnt_valid & ((cnt_q != 2'd2) | pop);

  always_comb begin
    pending_d = pending_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    if (flush) begin
      pending_d = '0;
      rr_ptr_d  = '0;
      cnt_d     = '0;
    end else begin
      if (push) pending_d[alu_done_index] = 1'b0;
      if (issue) begin
        pending_d[gnt_idx] = 1'b1;
        rr_ptr_d           = gnt_idx + RS_WIDTH'(1);
      end
      case ({issue, pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pending_q     <= '0;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      fifo_rd_q     <= 1'b0;
      fifo_wr_q     <= 1'b0;
      fifo_cnt_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_idx_q[i] <= '0;
        fifo_res_q[i] <= '0;
      end
      cal_q         <= 1'b0;
      issue_valid_q <= 1'b0;
      issue_index_q <= '0;
      alu_index_q   <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
    end else begin
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      if (flush) begin
        fifo_rd_q     <= 1'b0;
        fifo_wr_q     <= 1'b0;
        fifo_cnt_q    <= '0;
        cal_q         <= 1'b0;
        issue_valid_q <= 1'b0;
      end else begin
        // When full, push and pop share a slot: the head is read this cycle, then overwritten.
        if (push) begin
          fifo_idx_q[fifo_wr_q] <= alu_done_index;
          fifo_res_q[fifo_wr_q] <= alu_result;
          fifo_wr_q             <= ~fifo_wr_q;
        end
        if (pop) fifo_rd_q <= ~fifo_rd_q;
        case ({push, pop})
          2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
          2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
          default: fifo_cnt_q <= fifo_cnt_q;
        endcase
        cal_q         <= issue;
        issue_valid_q <= issue;
        if (issue) begin
          issue_index_q <= gnt_idx;
          alu_index_q   <= gnt_idx;
          alu_a_q       <= rs_a[gnt_idx*XLEN +: XLEN];
          alu_b_q       <= rs_b[gnt_idx*XLEN +: XLEN];
          alu_op_q      <= rs_op[gnt_idx*ALU_OP_W +: ALU_OP_W];
        end
      end
    end
  end

  assign cal         = cal_q;
  assign issue_valid = issue_valid_q;
  assign issue_index = issue_index_q;
  assign alu_index   = alu_index_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign wb_valid    = (fifo_cnt_q != 2'd0);
  assign wb_index    = fifo_idx_q[fifo_rd_q];
  assign wb_result   = fifo_res_q[fifo_rd_q];

endmodule
